z88_mem_sched: RTL and testbench
================================

// Module: z88_mem_sched
// PURPOSE
//  Time-slotted scheduler sharing the 16-bit internal SRAM between three requesters: Z80 (cpu_*), LCD fetcher (lcd_*) and host image loader (hst_*).
//  Each access uses one 4-clock slot. Even slots prefer CPU, odd slots prefer LCD; unused slots go to the other one, then to the host.
//  Sits between z88_blink/z88_screen address outputs and the ram_* pins in z88_top.
// PARAMETERS
//  ADDR_W     19  byte-address width of every requester
//  STARVE_LIM 8   waiting slots after which the host pre-empts the non-preferred owner
// PORTS
//  clk        in   1       system clock
//  rst        in   1       synchronous reset, active-high
//  cpu_req    in   1       CPU request; held with addr/we/wdata until cpu_ack
//  cpu_we     in   1       1=write, 0=read
//  cpu_addr   in   ADDR_W  CPU byte address
//  cpu_wdata  in   8       CPU write byte
//  cpu_ack    out  1       one-clock completion pulse
//  cpu_rdata  out  8       read byte, valid while cpu_ack=1
//  lcd_req    in   1       LCD read request (read-only requester)
//  lcd_addr   in   ADDR_W  LCD byte address
//  lcd_ack    out  1       completion pulse
//  lcd_rdata  out  8       read byte, valid while lcd_ack=1
//  hst_req/hst_we/hst_addr/hst_wdata/hst_ack/hst_rdata  same as cpu_*
//  slot_ph    out  2       current phase P0..P3
//  slot_odd   out  1       1=odd (LCD-preferred) slot
//  ram_ce_n/ram_oe_n/ram_we_n  out 1 each  SRAM strobes, active-low
//  ram_be_n   out  2       byte-lane enables, active-low
//  ram_addr   out  ADDR_W  word address {1'b0, addr[ADDR_W-1:1]}
//  ram_wdata  out  16      {wdata, wdata}
//  ram_rdata  in   16      SRAM read data
// BEHAVIOUR
//  Reset, sync on rst=1: strobes=1, ram_be_n=2'b11, ram_addr/ram_wdata=0, acks=0, rdata=0, slot_ph=P0, slot_odd=0, owner=NONE, starve cnt=0.
//  Phases run freely P0->P1->P2->P3->P0. slot_odd toggles on the P3->P0 edge.
//  P0: pick the owner and register its addr/we/wdata and the lane. A requester whose ack is high this cycle is excluded from the pick.
//   Even slot priority: CPU > LCD > HST. Odd slot priority: LCD > CPU > HST.
//   If starve cnt >= STARVE_LIM and hst_req=1, HST takes the slot unless the preferred owner requests.
//  P1-P3 with owner!=NONE: ram_ce_n=0.
//   Read: ram_oe_n=0 during P1-P3.
//   Write: ram_we_n=0 during P1-P2 only; addr and data are held through P3.
//  ram_be_n = addr[0] ? 2'b01 : 2'b10.
//  On the P3 edge, register the lane byte (addr[0] ? [15:8] : [7:0]) into the owner's rdata. Writes leave rdata unchanged.
//  The owner's ack is high for exactly the following P0 cycle.
//  Latency: req present at P0 -> ack 4 clocks later. Worst case for CPU/LCD: 8 clocks to slot start plus 4.
//  Starve cnt: +1 per slot in which hst_req=1 and HST is not owner (saturating). Cleared when HST owns a slot.
//  owner=NONE: strobes stay high all slot, ram_be_n=2'b11.
//  Simultaneous requests: resolved only at P0. A request that rises in P1-P3 waits for the next P0.
//  Requests dropped before ack: the access still completes and acks. The requester must ignore the ack.
//  rst mid-slot: strobes deassert on the same edge and no ack is issued for the aborted access.
// STRUCTURE
//  z88_mem_pkg: owner encoding OWN_NONE/CPU/LCD/HST, phase constants PH_P0..PH_P3, lane-select function.
//  Sub-module z88_mem_arb_pick: combinational owner pick from reqs, slot_odd, ack mask and starve flag.
//  Top: phase/slot counters, starve counter, capture regs, strobe regs, rdata/ack regs. All outputs registered.
// TESTING
//  1 Reset mid-write (P1) -> ram_we_n/ce_n=1 the next clock; no cpu_ack; slot_ph=P0, slot_odd=0.
//  2 CPU read 0x00003, ram_rdata=16'hA55A, even slot -> ram_addr=0x00001, be_n=01; cpu_rdata=8'hA5 with a 1-clk ack.
//  3 CPU+LCD requesting continuously -> grants alternate CPU, LCD, CPU...; each ack exactly 1 clk.
//  4 CPU write 0x00010=8'h3C -> we_n low for 2 clks; ram_wdata=16'h3C3C, be_n=10; cpu_rdata unchanged.
//  5 hst_req held, CPU+LCD saturating -> HST is granted on the 9th waiting slot in a non-preferred-owner position; starve cnt clears.
//  6 No requests -> ce/oe/we stay 1, be_n=11 across 3 slots; slot_odd toggles every 4 clks.

Source files
------------

// File: rtl/z88_mem_pkg.sv
// Shared types for the Z88 SRAM slot scheduler.
// Includes the owner encoding, the slot phases and the byte-lane helpers.
package z88_mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LCD  = 2'd2,
        OWN_HST  = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        PH_P0 = 2'd0,
        PH_P1 = 2'd1,
        PH_P2 = 2'd2,
        PH_P3 = 2'd3
    } phase_e;

    // Odd byte addresses live in the upper half of the 16-bit SRAM word.
    function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic odd_byte);
        return odd_byte ? word[15:8] : word[7:0];
    endfunction

    function automatic logic [1:0] lane_be_n(input logic odd_byte);
        return odd_byte ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/z88_mem_arb_pick.sv
// Combinational slot-owner selection for the Z88 SRAM scheduler.
// A requester that is being acked this cycle cannot win the new slot.
module z88_mem_arb_pick
    import z88_mem_pkg::*;
(
    input  logic   cpu_req,
    input  logic   lcd_req,
    input  logic   hst_req,
    input  logic   cpu_ack,
    input  logic   lcd_ack,
    input  logic   hst_ack,
    input  logic   slot_odd,
    input  logic   starve,
    output owner_e owner
);

    logic   cpu_ok;
    logic   lcd_ok;
    logic   hst_ok;
    logic   pref_ok;
    logic   other_ok;
    owner_e pref_own;
    owner_e other_own;

    // A starved host may only displace the non-preferred requester.
    always_comb begin
        cpu_ok    = cpu_req & ~cpu_ack;
        lcd_ok    = lcd_req & ~lcd_ack;
        hst_ok    = hst_req & ~hst_ack;
        pref_own  = slot_odd ? OWN_LCD : OWN_CPU;
        other_own = slot_odd ? OWN_CPU : OWN_LCD;
        pref_ok   = slot_odd ? lcd_ok : cpu_ok;
        other_ok  = slot_odd ? cpu_ok : lcd_ok;
        owner     = OWN_NONE;
        if (pref_ok)
            owner = pref_own;
        else if (starve && hst_ok)
            owner = OWN_HST;
        else if (other_ok)
            owner = other_own;
        else if (hst_ok)
            owner = OWN_HST;
    end

endmodule

// File: rtl/z88_mem_sched.sv
// Four-clock time-slotted scheduler sharing the 16-bit SRAM between the CPU, LCD and host.
// The owner is picked in P0, the SRAM is strobed during P1-P3, and the ack is issued in the next P0.
module z88_mem_sched
    import z88_mem_pkg::*;
#(
    parameter int ADDR_W     = 19,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              lcd_req,
    input  logic [ADDR_W-1:0] lcd_addr,
    output logic              lcd_ack,
    output logic [7:0]        lcd_rdata,
    input  logic              hst_req,
    input  logic              hst_we,
    input  logic [ADDR_W-1:0] hst_addr,
    input  logic [7:0]        hst_wdata,
    output logic              hst_ack,
    output logic [7:0]        hst_rdata,
    output logic [1:0]        slot_ph,
    output logic              slot_odd,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [1:0]        ram_be_n,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata
);

    localparam int                CNT_W      = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIM);

    phase_e            ph;
    phase_e            ph_next;
    owner_e            pick;
    owner_e            own;
    logic              own_we;
    logic              own_odd;
    logic [CNT_W-1:0]  starve_cnt;
    logic              starve;
    logic [ADDR_W-1:0] pick_addr;
    logic              pick_we;
    logic [7:0]        pick_wdata;

    assign slot_ph = ph;
    assign starve  = (starve_cnt >= STARVE_MAX);

    z88_mem_arb_pick u_pick (
        .cpu_req  (cpu_req),
        .lcd_req  (lcd_req),
        .hst_req  (hst_req),
        .cpu_ack  (cpu_ack),
        .lcd_ack  (lcd_ack),
        .hst_ack  (hst_ack),
        .slot_odd (slot_odd),
        .starve   (starve),
        .owner    (pick)
    );

    always_ff @(posedge clk) begin
        if (rst)
            ph <= PH_P0;
        else
            ph <= ph_next;
    end

    always_comb begin
        ph_next = PH_P0;
        unique case (ph)
            PH_P0: ph_next = PH_P1;
            PH_P1: ph_next = PH_P2;
            PH_P2: ph_next = PH_P3;
            PH_P3: ph_next = PH_P0;
        endcase
    end

    always_comb begin
        pick_addr  = '0;
        pick_we    = 1'b0;
        pick_wdata = '0;
        case (pick)
            OWN_CPU: begin
                pick_addr  = cpu_addr;
                pick_we    = cpu_we;
                pick_wdata = cpu_wdata;
            end
            OWN_LCD: pick_addr = lcd_addr;
            OWN_HST: begin
                pick_addr  = hst_addr;
                pick_we    = hst_we;
                pick_wdata = hst_wdata;
            end
            default: ;
        endcase
    end

    // Write strobe is released one phase early so address and data stay stable past its rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_odd   <= 1'b0;
            own        <= OWN_NONE;
            own_we     <= 1'b0;
            own_odd    <= 1'b0;
            starve_cnt <= '0;
            ram_ce_n   <= 1'b1;
            ram_oe_n   <= 1'b1;
            ram_we_n   <= 1'b1;
            ram_be_n   <= 2'b11;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            cpu_ack    <= 1'b0;
            lcd_ack    <= 1'b0;
            hst_ack    <= 1'b0;
            cpu_rdata  <= '0;
            lcd_rdata  <= '0;
            hst_rdata  <= '0;
        end else begin
            cpu_ack <= 1'b0;
            lcd_ack <= 1'b0;
            hst_ack <= 1'b0;
            unique case (ph)
                PH_P0: begin
                    own     <= pick;
                    own_we  <= pick_we;
                    own_odd <= pick_addr[0];
                    if (pick == OWN_HST)
                        starve_cnt <= '0;
                    else if (hst_req && starve_cnt != STARVE_MAX)
                        starve_cnt <= starve_cnt + 1'b1;
                    if (pick != OWN_NONE) begin
                        ram_ce_n  <= 1'b0;
                        ram_oe_n  <= pick_we;
                        ram_we_n  <= ~pick_we;
                        ram_be_n  <= lane_be_n(pick_addr[0]);
                        ram_addr  <= {1'b0, pick_addr[ADDR_W-1:1]};
                        ram_wdata <= {pick_wdata, pick_wdata};
                    end
                end
                PH_P1: ;
                PH_P2: ram_we_n <= 1'b1;
                PH_P3: begin
                    slot_odd <= ~slot_odd;
                    ram_ce_n <= 1'b1;
                    ram_oe_n <= 1'b1;
                    ram_be_n <= 2'b11;
                    case (own)
                        OWN_CPU: begin
                            cpu_ack <= 1'b1;
                            if (!own_we)
                                cpu_rdata <= lane_byte(ram_rdata, own_odd);
                        end
                        OWN_LCD: begin
                            lcd_ack   <= 1'b1;
                            lcd_rdata <= lane_byte(ram_rdata, own_odd);
                        end
                        OWN_HST: begin
                            hst_ack <= 1'b1;
                            if (!own_we)
                                hst_rdata <= lane_byte(ram_rdata, own_odd);
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z88_mem_sched.sv
// Self-checking bench for z88_mem_sched: per-slot stimulus with a scoreboard of expected acks and read bytes.
// Each test task drives whole slots and adds its own targeted checks.
module tb_z88_mem_sched;

    localparam logic [1:0] O_NONE = 2'd0;
    localparam logic [1:0] O_CPU  = 2'd1;
    localparam logic [1:0] O_LCD  = 2'd2;
    localparam logic [1:0] O_HST  = 2'd3;

    typedef struct {
        logic [1:0] own;
        logic       rd;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req, cpu_we, lcd_req, hst_req, hst_we;
    logic [18:0] cpu_addr, lcd_addr, hst_addr;
    logic [7:0]  cpu_wdata, hst_wdata;
    logic        cpu_ack, lcd_ack, hst_ack;
    logic [7:0]  cpu_rdata, lcd_rdata, hst_rdata;
    logic [1:0]  slot_ph;
    logic        slot_odd;
    logic        ram_ce_n, ram_oe_n, ram_we_n;
    logic [1:0]  ram_be_n;
    logic [18:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [15:0] sram_word;

    int          n_vec = 0;
    int          n_err = 0;
    int          slot_no = 0;
    logic        m_odd;
    logic [1:0]  m_prev;
    int          m_starve;
    exp_t        sb[$];

    logic        obs_ce[4];
    logic        obs_oe[4];
    logic        obs_we[4];
    logic [1:0]  obs_be[4];
    logic        obs_odd[4];
    logic [18:0] obs_addr;
    logic [15:0] obs_wdata;

    assign ram_rdata = sram_word;

    always #5 clk = ~clk;

    z88_mem_sched #(.ADDR_W(19), .STARVE_LIM(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .lcd_req   (lcd_req),
        .lcd_addr  (lcd_addr),
        .lcd_ack   (lcd_ack),
        .lcd_rdata (lcd_rdata),
        .hst_req   (hst_req),
        .hst_we    (hst_we),
        .hst_addr  (hst_addr),
        .hst_wdata (hst_wdata),
        .hst_ack   (hst_ack),
        .hst_rdata (hst_rdata),
        .slot_ph   (slot_ph),
        .slot_odd  (slot_odd),
        .ram_ce_n  (ram_ce_n),
        .ram_oe_n  (ram_oe_n),
        .ram_we_n  (ram_we_n),
        .ram_be_n  (ram_be_n),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        lcd_req = 1'b0; lcd_addr = '0;
        hst_req = 1'b0; hst_we = 1'b0; hst_addr = '0; hst_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        m_odd    = 1'b0;
        m_prev   = O_NONE;
        m_starve = 0;
        sb.delete();
    endtask

    // Priority model: preferred side first, then a starved host, then the other side, then the host.
    function automatic logic [1:0] model_pick(input logic c, input logic l, input logic h,
                                               input logic odd, input logic [1:0] prev, input bit starved);
        bit cv, lv, hv;
        cv = c && (prev != O_CPU);
        lv = l && (prev != O_LCD);
        hv = h && (prev != O_HST);
        if (odd) begin
            if (lv) return O_LCD;
            if (starved && hv) return O_HST;
            if (cv) return O_CPU;
        end else begin
            if (cv) return O_CPU;
            if (starved && hv) return O_HST;
            if (lv) return O_LCD;
        end
        if (hv) return O_HST;
        return O_NONE;
    endfunction

    // Entered at P0 (#1 after the edge); returns at the following P0.
    task automatic run_slot(input logic c_r, input logic c_w, input logic [18:0] c_a, input logic [7:0] c_d,
                            input logic l_r, input logic [18:0] l_a,
                            input logic h_r, input logic h_w, input logic [18:0] h_a, input logic [7:0] h_d);
        exp_t        e;
        logic [2:0]  exp_ack;
        logic [2:0]  got_ack;
        logic [7:0]  got_rd;
        logic [1:0]  own;
        logic [18:0] a;
        logic        w;
        slot_no++;
        e = '{O_NONE, 1'b0, 8'h00};
        if (sb.size() > 0) e = sb.pop_front();
        exp_ack = {e.own == O_CPU, e.own == O_LCD, e.own == O_HST};
        got_ack = {cpu_ack, lcd_ack, hst_ack};
        n_vec++;
        if (got_ack !== exp_ack) begin
            n_err++;
            $display("[TB] FAIL sb_ack slot %0d: got cpu/lcd/hst=%b want %b", slot_no, got_ack, exp_ack);
        end
        if (e.rd) begin
            got_rd = (e.own == O_CPU) ? cpu_rdata : (e.own == O_LCD) ? lcd_rdata : hst_rdata;
            n_vec++;
            if (got_rd !== e.data) begin
                n_err++;
                $display("[TB] FAIL sb_rdata slot %0d owner %0d: got %h want %h", slot_no, e.own, got_rd, e.data);
            end
        end
        cpu_req = c_r; cpu_we = c_w; cpu_addr = c_a; cpu_wdata = c_d;
        lcd_req = l_r; lcd_addr = l_a;
        hst_req = h_r; hst_we = h_w; hst_addr = h_a; hst_wdata = h_d;
        own = model_pick(c_r, l_r, h_r, m_odd, m_prev, m_starve >= 8);
        a = (own == O_CPU) ? c_a : (own == O_LCD) ? l_a : h_a;
        w = (own == O_CPU) ? c_w : (own == O_HST) ? h_w : 1'b0;
        e.own  = own;
        e.rd   = (own != O_NONE) && !w;
        e.data = a[0] ? sram_word[15:8] : sram_word[7:0];
        sb.push_back(e);
        if (own == O_HST) m_starve = 0;
        else if (h_r) m_starve++;
        m_prev = own;
        for (int p = 0; p < 4; p++) begin
            if (p > 0) begin
                tick();
                n_vec++;
                if ({cpu_ack, lcd_ack, hst_ack} !== 3'b000) begin
                    n_err++;
                    $display("[TB] FAIL ack_pulse slot %0d ph %0d: got %b want 000", slot_no, p,
                             {cpu_ack, lcd_ack, hst_ack});
                end
            end
            obs_ce[p] = ram_ce_n; obs_oe[p] = ram_oe_n; obs_we[p] = ram_we_n;
            obs_be[p] = ram_be_n; obs_odd[p] = slot_odd;
            if (p == 1) begin
                obs_addr  = ram_addr;
                obs_wdata = ram_wdata;
            end
            n_vec++;
            if (slot_ph !== p[1:0]) begin
                n_err++;
                $display("[TB] FAIL slot_ph slot %0d: got %0d want %0d", slot_no, slot_ph, p);
            end
        end
        tick();
        m_odd = ~m_odd;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({ram_ce_n, ram_oe_n, ram_we_n, ram_be_n} !== 5'b11111 || ram_addr !== '0 || ram_wdata !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_ram: got ce/oe/we/be=%b addr=%h wdata=%h want 11111 0 0",
                     {ram_ce_n, ram_oe_n, ram_we_n, ram_be_n}, ram_addr, ram_wdata);
        end
        n_vec++;
        if ({cpu_ack, lcd_ack, hst_ack} !== 3'b000 || {cpu_rdata, lcd_rdata, hst_rdata} !== 24'h0 ||
            slot_ph !== 2'd0 || slot_odd !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_ctl: got acks=%b rdata=%h ph=%0d odd=%b want 000 0 0 0",
                     {cpu_ack, lcd_ack, hst_ack}, {cpu_rdata, lcd_rdata, hst_rdata}, slot_ph, slot_odd);
        end
    endtask

    task automatic test_reset_mid_write();
        bit saw_ack;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00020; cpu_wdata = 8'h55;
        tick();
        n_vec++;
        if (ram_we_n !== 1'b0 || ram_ce_n !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL midrst_pre: got we_n=%b ce_n=%b want 0 0", ram_we_n, ram_ce_n);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cpu_req = 1'b0;
        n_vec++;
        if (ram_we_n !== 1'b1 || ram_ce_n !== 1'b1 || slot_ph !== 2'd0 || slot_odd !== 1'b0 || cpu_ack !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL midrst_post: got we_n=%b ce_n=%b ph=%0d odd=%b ack=%b want 1 1 0 0 0",
                     ram_we_n, ram_ce_n, slot_ph, slot_odd, cpu_ack);
        end
        saw_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cpu_ack !== 1'b0) saw_ack = 1'b1;
        end
        n_vec++;
        if (saw_ack) begin
            n_err++;
            $display("[TB] FAIL midrst_noack: got cpu_ack pulse want none");
        end
    endtask

    task automatic test_cpu_read();
        do_reset();
        sram_word = 16'hA55A;
        run_slot(1'b1, 1'b0, 19'h00003, 8'h00, 1'b0, '0, 1'b0, 1'b0, '0, 8'h00);
        n_vec++;
        if (obs_addr !== 19'h00001 || obs_be[1] !== 2'b01) begin
            n_err++;
            $display("[TB] FAIL read_addr: got addr=%h be_n=%b want 00001 01", obs_addr, obs_be[1]);
        end
        n_vec++;
        if ({obs_ce[1], obs_oe[1], obs_oe[3], obs_we[2], obs_ce[0]} !== 5'b00011) begin
            n_err++;
            $display("[TB] FAIL read_strobes: got %b want 00011",
                     {obs_ce[1], obs_oe[1], obs_oe[3], obs_we[2], obs_ce[0]});
        end
        n_vec++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
            n_err++;
            $display("[TB] FAIL read_data: got ack=%b rdata=%h want 1 a5", cpu_ack, cpu_rdata);
        end
    endtask

    task automatic test_cpu_write();
        run_slot(1'b0, 1'b0, '0, 8'h00, 1'b0, '0, 1'b0, 1'b0, '0, 8'h00);
        sram_word = 16'h1234;
        run_slot(1'b1, 1'b1, 19'h00010, 8'h3C, 1'b0, '0, 1'b0, 1'b0, '0, 8'h00);
        n_vec++;
        if ({obs_we[0], obs_we[1], obs_we[2], obs_we[3]} !== 4'b1001) begin
            n_err++;
            $display("[TB] FAIL write_we: got P0..P3 we_n=%b want 1001",
                     {obs_we[0], obs_we[1], obs_we[2], obs_we[3]});
        end
        n_vec++;
        if (obs_wdata !== 16'h3C3C || obs_be[1] !== 2'b10 || obs_addr !== 19'h00008 || obs_oe[1] !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL write_bus: got wdata=%h be_n=%b addr=%h oe_n=%b want 3c3c 10 00008 1",
                     obs_wdata, obs_be[1], obs_addr, obs_oe[1]);
        end
        n_vec++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hA5) begin
            n_err++;
            $display("[TB] FAIL write_rdata: got ack=%b rdata=%h want 1 a5", cpu_ack, cpu_rdata);
        end
        run_slot(1'b0, 1'b0, '0, 8'h00, 1'b0, '0, 1'b0, 1'b0, '0, 8'h00);
    endtask

    task automatic test_back_to_back();
        do_reset();
        sram_word = 16'hC3E1;
        for (int s = 1; s <= 6; s++) begin
            run_slot(1'b1, 1'b0, 19'h00101, 8'h00, 1'b1, 19'h00200, 1'b0, 1'b0, '0, 8'h00);
            n_vec++;
            if ({cpu_ack, lcd_ack, hst_ack} !== ((s % 2 == 1) ? 3'b100 : 3'b010)) begin
                n_err++;
                $display("[TB] FAIL alternate slot %0d: got cpu/lcd/hst=%b want %b", s,
                         {cpu_ack, lcd_ack, hst_ack}, (s % 2 == 1) ? 3'b100 : 3'b010);
            end
        end
        run_slot(1'b0, 1'b0, '0, 8'h00, 1'b0, '0, 1'b0, 1'b0, '0, 8'h00);
    endtask

    task automatic test_starve();
        do_reset();
        sram_word = 16'h7E81;
        for (int s = 1; s <= 18; s++) begin
            run_slot(m_odd, 1'b0, 19'h00040, 8'h00, ~m_odd, 19'h00041, 1'b1, 1'b0, 19'h00051, 8'h00);
            n_vec++;
            if (hst_ack !== ((s == 9 || s == 18) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("[TB] FAIL starve slot %0d: got hst_ack=%b want %b", s, hst_ack,
                         (s == 9 || s == 18) ? 1'b1 : 1'b0);
            end
        end
        run_slot(1'b0, 1'b0, '0, 8'h00, 1'b0, '0, 1'b0, 1'b0, '0, 8'h00);
    endtask

    task automatic test_idle();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            run_slot(1'b0, 1'b0, '0, 8'h00, 1'b0, '0, 1'b0, 1'b0, '0, 8'h00);
            for (int p = 0; p < 4; p++) begin
                n_vec++;
                if ({obs_ce[p], obs_oe[p], obs_we[p], obs_be[p]} !== 5'b11111 || obs_odd[p] !== k[0]) begin
                    n_err++;
                    $display("[TB] FAIL idle slot %0d ph %0d: got ce/oe/we/be=%b odd=%b want 11111 %b", k, p,
                             {obs_ce[p], obs_oe[p], obs_we[p], obs_be[p]}, obs_odd[p], k[0]);
                end
            end
        end
    endtask

    initial begin
        sram_word = 16'h0000;
        idle_inputs();
        test_reset();
        test_reset_mid_write();
        test_cpu_read();
        test_cpu_write();
        test_back_to_back();
        test_starve();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
